// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types, widths and CRC step for the config loader
package cfg_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, LOAD, CHECK, ERR} cfg_state_e;

  localparam logic [7:0] CRC8_POLY     = 8'h07;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam int         PROG_W        = 69;

  // prog field map of the connection-block tile
  localparam int LUT_MSB   = 68;
  localparam int LUT_LSB   = 52;
  localparam int SB_MSB    = 51;
  localparam int SB_LSB    = 20;
  localparam int ISEL_MSB  = 19;
  localparam int ISEL_LSB  = 8;
  localparam int IOSEL_MSB = 7;
  localparam int IOSEL_LSB = 0;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// rtl/cfg_loader_if.sv - config port and prog bus; CFG_READBACK_EN adds rb_req/rb_dout
interface cfg_loader_if #(parameter int PROG_W = cfg_pkg::PROG_W);

  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_din;
  logic [PROG_W-1:0] prog;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;

`ifdef CFG_READBACK_EN
  logic              rb_req;
  logic              rb_dout;

  modport master (output cfg_start, cfg_valid, cfg_din, rb_req,
                  input  prog, cfg_busy, cfg_done, cfg_err, rb_dout);
  modport slave  (input  cfg_start, cfg_valid, cfg_din, rb_req,
                  output prog, cfg_busy, cfg_done, cfg_err, rb_dout);
`else
  modport master (output cfg_start, cfg_valid, cfg_din,
                  input  prog, cfg_busy, cfg_done, cfg_err);
  modport slave  (input  cfg_start, cfg_valid, cfg_din,
                  output prog, cfg_busy, cfg_done, cfg_err);
`endif

endinterface

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 (poly 0x07, init 0, no reflection)
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 8'h00;
    end else if (clear_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc8_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - framed serial config loader with atomic prog commit; readback under CFG_READBACK_EN
module cfg_loader
  import cfg_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int         SYNC_TIMEOUT = 32
)
(
  input  logic         clb_clk,
  input  logic         clb_rst,
  cfg_loader_if.slave  bus_if
);

  cfg_state_e        state_q;
  logic [7:0]        win_q, rx_q, cnt_q;
  logic [PROG_W-1:0] shadow_q, prog_q;
  logic              done_q, err_q;
  logic [7:0]        win_d, rx_d, crc;
  logic [PROG_W-1:0] shadow_d;
  logic              crc_en;

  assign win_d    = {win_q[6:0], bus_if.cfg_din};
  assign rx_d     = {rx_q[6:0], bus_if.cfg_din};
  assign shadow_d = {shadow_q[PROG_W-2:0], bus_if.cfg_din};
  assign crc_en   = (state_q == LOAD) && bus_if.cfg_valid && !bus_if.cfg_start;

  crc8_serial u_crc (
    .clk_i   (clb_clk),
    .rst_i   (clb_rst),
    .clear_i (bus_if.cfg_start),
    .en_i    (crc_en),
    .bit_i   (bus_if.cfg_din),
    .crc_o   (crc)
  );

  // cfg_start always wins over a bit presented in the same cycle
  always_ff @(posedge clb_clk or posedge clb_rst) begin
    if (clb_rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      prog_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus_if.cfg_start) begin
        state_q  <= SYNC;
        win_q    <= '0;
        rx_q     <= '0;
        cnt_q    <= '0;
        shadow_q <= '0;
        err_q    <= 1'b0;
      end else if (bus_if.cfg_valid) begin
        case (state_q)
          SYNC: begin
            win_q <= win_d;
            if (win_d == SYNC_WORD) begin
              state_q <= LOAD;
              cnt_q   <= '0;
            end else if (cnt_q == 8'(SYNC_TIMEOUT - 1)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          LOAD: begin
            shadow_q <= shadow_d;
            if (cnt_q == 8'(PROG_W - 1)) begin
              state_q <= CHECK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          CHECK: begin
            rx_q <= rx_d;
            if (cnt_q == 8'd7) begin
              cnt_q <= '0;
              if (rx_d == crc) begin
                prog_q  <= shadow_q;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_if.prog     = prog_q;
  assign bus_if.cfg_done = done_q;
  assign bus_if.cfg_err  = err_q;

`ifdef CFG_READBACK_EN
  logic              rb_active_q, rb_dout_q;
  logic [7:0]        rb_cnt_q;
  logic [PROG_W-1:0] rb_sr_q;

  // rb_cnt_q counts bits already presented on rb_dout
  always_ff @(posedge clb_clk or posedge clb_rst) begin
    if (clb_rst) begin
      rb_active_q <= 1'b0;
      rb_dout_q   <= 1'b0;
      rb_cnt_q    <= '0;
      rb_sr_q     <= '0;
    end else if (bus_if.cfg_start) begin
      rb_active_q <= 1'b0;
      rb_dout_q   <= 1'b0;
      rb_cnt_q    <= '0;
    end else if (!rb_active_q) begin
      if (bus_if.rb_req && state_q == IDLE) begin
        rb_active_q <= 1'b1;
        rb_dout_q   <= prog_q[PROG_W-1];
        rb_sr_q     <= {prog_q[PROG_W-2:0], 1'b0};
        rb_cnt_q    <= 8'd1;
      end
    end else if (rb_cnt_q == 8'(PROG_W)) begin
      rb_active_q <= 1'b0;
      rb_dout_q   <= 1'b0;
      rb_cnt_q    <= '0;
    end else begin
      rb_dout_q <= rb_sr_q[PROG_W-1];
      rb_sr_q   <= {rb_sr_q[PROG_W-2:0], 1'b0};
      rb_cnt_q  <= rb_cnt_q + 8'd1;
    end
  end

  assign bus_if.rb_dout  = rb_dout_q;
  assign bus_if.cfg_busy = (state_q inside {SYNC, LOAD, CHECK}) || rb_active_q;
`else
  assign bus_if.cfg_busy = (state_q inside {SYNC, LOAD, CHECK});
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - scoreboard bench for cfg_loader; readback checks under CFG_READBACK_EN
module tb_cfg_loader;

  localparam int W = 69;
  localparam logic [W-1:0] PAT = 69'h1_5555_5555_5555_5555;

  typedef struct {
    bit           is_err;
    logic [W-1:0] prog;
  } exp_t;

  logic clb_clk = 1'b0;
  logic clb_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic err_prev = 1'b0;

  cfg_loader_if #(.PROG_W(W)) bus ();

  cfg_loader dut (
    .clb_clk (clb_clk),
    .clb_rst (clb_rst),
    .bus_if  (bus)
  );

  always #5 clb_clk = ~clb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [W-1:0] p);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[7] ^ p[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Monitor: every done pulse or err rising edge pops one expected event
  always @(negedge clb_clk) begin
    if (clb_rst) begin
      err_prev <= 1'b0;
    end else begin
      if (bus.cfg_done || (bus.cfg_err && !err_prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected done=%0b err=%0b", bus.cfg_done, bus.cfg_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_kind_is_err", {127'd0, bus.cfg_err && !bus.cfg_done}, {127'd0, e.is_err});
          chk("sb_prog", 128'(bus.prog), 128'(e.prog));
        end
      end
      err_prev <= bus.cfg_err;
    end
  end

  task automatic expect_evt(input bit is_err, input logic [W-1:0] p);
    exp_t e;
    e.is_err = is_err;
    e.prog   = p;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clb_clk);
    #1;
  endtask

  task automatic do_start(input logic v, input logic d);
    bus.cfg_start = 1'b1;
    bus.cfg_valid = v;
    bus.cfg_din   = d;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_din   = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 40) begin
          bus.cfg_valid = 1'b0;
          bus.cfg_din   = 1'($urandom);
          tick();
        end
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_din   = v[i];
      tick();
      bus.cfg_valid = 1'b0;
      bus.cfg_din   = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] p, input logic [7:0] crc, input bit gaps);
    send_bits(128'hA5, 8, gaps);
    send_bits(128'(p), W, gaps);
    send_bits(128'(crc), 8, gaps);
  endtask

  initial begin
    logic seen_done;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_din   = 1'b0;
`ifdef CFG_READBACK_EN
    bus.rb_req    = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_prog", 128'(bus.prog), 128'd0);
    chk("rst_busy", {127'd0, bus.cfg_busy}, 128'd0);
    chk("rst_done", {127'd0, bus.cfg_done}, 128'd0);
    chk("rst_err", {127'd0, bus.cfg_err}, 128'd0);
    clb_rst = 1'b0;
    tick();

    // good load with cfg_valid gaps
    do_start(1'b0, 1'b0);
    expect_evt(1'b0, PAT);
    send_frame(PAT, crc_model(PAT), 1'b1);
    chk("pat_done_pulse", {127'd0, bus.cfg_done}, 128'd1);
    chk("pat_prog", 128'(bus.prog), 128'(PAT));
    tick();

`ifdef CFG_READBACK_EN
    begin
      logic [W-1:0] cap;
      logic busy_low;
      busy_low = 1'b0;
      bus.rb_req = 1'b1;
      tick();
      bus.rb_req = 1'b0;
      for (int k = 0; k < W; k++) begin
        cap[W-1-k] = bus.rb_dout;
        if (!bus.cfg_busy) busy_low = 1'b1;
        tick();
      end
      chk("rb_data", 128'(cap), 128'(PAT));
      chk("rb_busy_low_seen", {127'd0, busy_low}, 128'd0);
      chk("rb_dout_after", {127'd0, bus.rb_dout}, 128'd0);
      chk("rb_busy_after", {127'd0, bus.cfg_busy}, 128'd0);
    end
`endif

    // 40-bit abort by cfg_start
    do_start(1'b0, 1'b0);
    send_bits(128'hA5, 8, 1'b0);
    send_bits(128'(PAT >> 37), 32, 1'b0);
    do_start(1'b1, 1'b1);
    chk("abort_prog", 128'(bus.prog), 128'(PAT));
    chk("abort_busy", {127'd0, bus.cfg_busy}, 128'd1);

    // reset mid-LOAD
    do_start(1'b0, 1'b0);
    send_bits(128'hA5, 8, 1'b0);
    send_bits(128'hFFFFF, 20, 1'b0);
    clb_rst = 1'b1;
    #2;
    chk("midrst_prog", 128'(bus.prog), 128'd0);
    chk("midrst_busy", {127'd0, bus.cfg_busy}, 128'd0);
    chk("midrst_err", {127'd0, bus.cfg_err}, 128'd0);
    tick();
    clb_rst = 1'b0;
    send_bits(128'hA5, 8, 1'b0);
    chk("idle_ignores_bits", {127'd0, bus.cfg_busy}, 128'd0);

    // all-zero frame, CRC 0x00
    do_start(1'b0, 1'b0);
    expect_evt(1'b0, '0);
    send_frame('0, 8'h00, 1'b0);
    chk("zero_done_now", {127'd0, bus.cfg_done}, 128'd1);
    tick();
    chk("zero_done_gone", {127'd0, bus.cfg_done}, 128'd0);
    chk("zero_prog", 128'(bus.prog), 128'd0);
    chk("zero_err", {127'd0, bus.cfg_err}, 128'd0);

    // reload pattern, then bad CRC must keep it
    do_start(1'b0, 1'b0);
    expect_evt(1'b0, PAT);
    send_frame(PAT, crc_model(PAT), 1'b0);
    do_start(1'b0, 1'b0);
    expect_evt(1'b1, PAT);
    send_frame('0, 8'h01, 1'b0);
    chk("badcrc_err", {127'd0, bus.cfg_err}, 128'd1);
    seen_done = bus.cfg_done;
    repeat (6) begin
      tick();
      seen_done = seen_done | bus.cfg_done;
    end
    chk("badcrc_no_done", {127'd0, seen_done}, 128'd0);
    chk("badcrc_err_sticky", {127'd0, bus.cfg_err}, 128'd1);
    chk("badcrc_prog_kept", 128'(bus.prog), 128'(PAT));

    // sync timeout; start-cycle bit must not count
    do_start(1'b1, 1'b0);
    chk("start_clears_err", {127'd0, bus.cfg_err}, 128'd0);
    send_bits(128'd0, 31, 1'b0);
    chk("to_err_bit31", {127'd0, bus.cfg_err}, 128'd0);
    chk("to_busy_bit31", {127'd0, bus.cfg_busy}, 128'd1);
    expect_evt(1'b1, PAT);
    send_bits(128'd0, 1, 1'b0);
    chk("to_err_bit32", {127'd0, bus.cfg_err}, 128'd1);
    chk("to_busy_bit32", {127'd0, bus.cfg_busy}, 128'd0);

    // sync word ending exactly on bit 32 wins over timeout
    do_start(1'b1, 1'b1);
    send_bits(128'hA5, 32, 1'b0);
    chk("edge_sync_err", {127'd0, bus.cfg_err}, 128'd0);
    chk("edge_sync_busy", {127'd0, bus.cfg_busy}, 128'd1);
    expect_evt(1'b0, '0);
    send_bits(128'd0, W + 8, 1'b0);
    chk("edge_sync_done", {127'd0, bus.cfg_done}, 128'd1);
    chk("edge_sync_prog", 128'(bus.prog), 128'd0);

    repeat (4) tick();
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
Serial configuration loader that drives the 69-bit prog word consumed by a connection-block tile (LUT, switch-box, input-select and in/out-select fields).
- Receives a framed bitstream: sync word, payload, CRC-8.
- Verifies the frame and commits the payload atomically to the prog output.
- Sits between the external config port and each tile's prog input; the tile sees only validated, glitch-free configuration.

Parameters:
PROG_W, 69, payload width; equals the tile prog width.
SYNC_WORD, 8'hA5, frame sync pattern, MSB first.
SYNC_TIMEOUT, 32, maximum valid bits searched for sync before error.

Ports:
clb_clk  input  1  clock.
clb_rst  input  1  reset.
cfg_start  input  1  single-cycle pulse; begins or restarts a load.
cfg_valid  input  1  cfg_din is valid this cycle.
cfg_din  input  1  serial config bit.
prog  output  PROG_W  committed configuration; bit PROG_W-1 is the first payload bit received.
cfg_busy  output  1  high in SYNC/LOAD/CHECK.
cfg_done  output  1  one-cycle pulse on successful commit.
cfg_err  output  1  sticky error flag.

Interface decision: one clock, clb_clk; reset clb_rst is asynchronous and active-high.

Behaviour:
- Reset (async, any state): state=IDLE; prog=0; shadow=0; crc=0; counters=0; cfg_busy=0; cfg_done=0; cfg_err=0.
- A bit is consumed only on a clb_clk edge with cfg_valid=1. With cfg_valid=0, all state holds.
- cfg_start in any state:
  - Clears cfg_err, shadow, crc and counters; next state SYNC.
  - prog is unchanged.
  - A bit presented in the same cycle as cfg_start is ignored (start wins).
- IDLE: waits for cfg_start. cfg_busy=0.
- SYNC:
  - Each bit shifts into an 8-bit window (new bit enters at LSB).
  - Window==SYNC_WORD after a shift -> LOAD.
  - Otherwise, when the SYNC_TIMEOUT-th bit is consumed without a match -> ERR.
  - The match test applies before the timeout test on the same bit.
- LOAD:
  - Each bit shifts into shadow, MSB first, and updates the CRC.
  - CRC is CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, serial: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 0).
  - After PROG_W bits -> CHECK.
- CHECK:
  - Shifts 8 received CRC bits, MSB first.
  - On the 8th bit, compare against the computed CRC.
  - Equal: prog<=shadow on that same edge; cfg_done=1 for the following cycle only; -> IDLE.
  - Unequal: -> ERR; prog untouched.
- ERR: cfg_err=1, cfg_busy=0; holds until cfg_start or reset.
- Latency: prog updates on the edge consuming the final CRC bit; cfg_done is registered alongside it.
- prog never shows partial data; it changes only on commit or reset.

Optional Feature:
CFG_READBACK_EN
- Defined: adds ports rb_req (input, 1) and rb_dout (output, 1).
  - rb_req pulse in IDLE starts a readback. rb_req in any other state is ignored.
  - Readback shifts out prog MSB first, one bit per cycle, for PROG_W cycles; rb_dout is first valid the cycle after rb_req.
  - cfg_busy is high during readback.
  - cfg_start aborts readback, and rb_dout returns to 0.
  - rb_dout=0 when not reading back and after reset.
- Undefined: neither port exists and there is no readback logic.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum {IDLE, SYNC, LOAD, CHECK, ERR};
  - CRC8_POLY=8'h07;
  - default SYNC_WORD;
  - PROG_W default 69 and its field offsets (LUT 68:52, SB 51:20, index-select 19:8, in/out-select 7:0).
- One sub-module, crc8_serial: clear, enable, bit inputs; 8-bit crc output.

Test Plan:
- Reset mid-LOAD after a prior good load -> prog=0, cfg_busy=0, cfg_err=0, state IDLE.
- cfg_start, then A5, then 69 zeros, then CRC 0x00 -> cfg_done pulses exactly one cycle after the last bit; prog=0; cfg_err=0.
- Same frame but CRC 0x01 -> cfg_err=1 and stays high; prog retains its previous value; cfg_done never asserts.
- cfg_start, then 32 bits of 0x00 -> cfg_err rises on the 32nd consumed bit. Repeat with A5 ending exactly at bit 32 -> enters LOAD, no error.
- Load payload 69'h1_5555_5555_5555_5555 with model-computed CRC and random cfg_valid gaps (≥30% low) -> prog equals payload; a 40-bit abort via cfg_start leaves prog unchanged.
- CFG_READBACK_EN: after the previous load, pulse rb_req -> rb_dout serializes 69'h1_5555_5555_5555_5555 MSB first over 69 cycles; cfg_busy is high throughout.
